// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard/stall unit.
//   state_t     - controller state (RUN, MEM_WAIT)
//   WAIT_CNT_W  - width of the memory-wait duration counter
//   ctrl_word_t - control word carried by the pipeline registers
//   BUBBLE_CTRL - control word loaded into a pipeline register on flush
package hazard_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam int WAIT_CNT_W = 16;

   // Minimal per-stage control word; a bubble is an ADDI x0,x0,0 with all
   // architectural side effects disabled.
   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        mem_read;
      logic [31:0] instr;
   } ctrl_word_t;

   localparam ctrl_word_t BUBBLE_CTRL = '{
      reg_write: 1'b0,
      mem_write: 1'b0,
      mem_read:  1'b0,
      instr:     32'h0000_0013
   };

endpackage

// File: rtl/hazard_stall_unit_perf.sv
// hazard_perf_counters: three saturating event counters for the hazard unit.
// Built only when HAZARD_PERF_CNT_EN is defined.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   lu_bubble       a load-use bubble is issued this cycle
//   mem_stall       the pipeline is frozen for a data-memory wait this cycle
//   br_flush        ID/EX is flushed by a taken branch/jump this cycle
//   load_use_cnt, mem_wait_cnt, flush_cnt   counter values (CNT_W bits)
module hazard_perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lu_bubble,
   input  logic             mem_stall,
   input  logic             br_flush,
   output logic [CNT_W-1:0] load_use_cnt,
   output logic [CNT_W-1:0] mem_wait_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_use_cnt <= '0;
         mem_wait_cnt <= '0;
         flush_cnt    <= '0;
      end else begin
         // Each counter holds at all-ones instead of wrapping.
         if (lu_bubble && (load_use_cnt != '1)) load_use_cnt <= load_use_cnt + ONE;
         if (mem_stall && (mem_wait_cnt != '1)) mem_wait_cnt <= mem_wait_cnt + ONE;
         if (br_flush  && (flush_cnt    != '1)) flush_cnt    <= flush_cnt + ONE;
      end
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush controller for the five-stage RISC-V core.
// Handles load-use hazards, taken branches/jumps resolved in EX and
// variable-latency data-memory accesses in MEM. Priority: memory stall >
// branch flush > load-use bubble. All stall/flush outputs are combinational.
// Optional feature macro: HAZARD_PERF_CNT_EN (adds three perf counters).
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   MemReadE, RD_E               load in EX and its destination register
//   Rs1_D, Rs2_D                 source registers of the instruction in ID
//   PCSrcE                       taken branch/jump resolved in EX
//   dmem_req_M, dmem_ready       MEM-stage access active / completes now
//   StallF/D/E/M                 hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD/E/W                   bubble into IF/ID, ID/EX, MEM/WB
//   mem_timeout                  sticky: a memory wait hit TIMEOUT_CYCLES
//   load_use_cnt, mem_wait_cnt, flush_cnt   perf counters (macro only)
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             MemReadE,
   input  logic [4:0]       RD_E,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic             PCSrcE,
   input  logic             dmem_req_M,
   input  logic             dmem_ready,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] load_use_cnt,
   output logic [CNT_W-1:0] mem_wait_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   if (CNT_W < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
      $error("hazard_stall_unit: parameter out of range");
   end

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(TIMEOUT_CYCLES);
   localparam logic [WAIT_CNT_W-1:0] WAIT_ONE    = WAIT_CNT_W'(1);

   state_t                  state, state_nxt;
   logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
   logic                    memstall;
   logic                    lu;

   assign memstall = dmem_req_M && !dmem_ready;
   assign lu       = MemReadE && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

   // Next state and wait-counter update.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         RUN: begin
            if (memstall) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = '0;
            end
         end
         MEM_WAIT: begin
            if (wait_cnt != '1) wait_cnt_nxt = wait_cnt + WAIT_ONE;
            if (dmem_ready)     state_nxt    = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         // Sets on the edge where the counter reaches the limit.
         if (state == MEM_WAIT && wait_cnt_nxt >= TIMEOUT_VAL) mem_timeout <= 1'b1;
      end
   end

   // Stall/flush outputs. A memory stall freezes everything and suppresses
   // the branch flush so a branch held in EX is replayed on the ready cycle.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (memstall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lu) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
      .clk          (clk),
      .rst          (rst),
      .lu_bubble    (lu && !PCSrcE && !memstall),
      .mem_stall    (memstall),
      .br_flush     (PCSrcE && !memstall),
      .load_use_cnt (load_use_cnt),
      .mem_wait_cnt (mem_wait_cnt),
      .flush_cnt    (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (TIMEOUT_CYCLES=4). Inputs change on
// the falling edge; combinational outputs are sampled 1 time unit later.
// Output vector order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
module tb_hazard_stall_unit;

   localparam int CNT_W = 32;

   logic clk = 1'b0;
   logic rst;
   logic MemReadE, PCSrcE, dmem_req_M, dmem_ready;
   logic [4:0] RD_E, Rs1_D, Rs2_D;
   logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] load_use_cnt, mem_wait_cnt, flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] NONE  = 7'b000_0000;
   localparam logic [6:0] LU    = 7'b110_0010;
   localparam logic [6:0] BR    = 7'b000_0110;
   localparam logic [6:0] MSTL  = 7'b111_1001;

   always #5 clk = ~clk;

   hazard_stall_unit #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .MemReadE(MemReadE), .RD_E(RD_E), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
      .PCSrcE(PCSrcE), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
      , .load_use_cnt(load_use_cnt), .mem_wait_cnt(mem_wait_cnt), .flush_cnt(flush_cnt)
`endif
   );

   wire [6:0] outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs on the falling edge, then let them settle.
   task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic br, input logic req,
                        input logic rdy);
      @(negedge clk);
      MemReadE = mr; RD_E = rd; Rs1_D = r1; Rs2_D = r2;
      PCSrcE = br; dmem_req_M = req; dmem_ready = rdy;
      #1;
   endtask

   initial begin
      rst = 1'b0;
      MemReadE = 0; RD_E = 0; Rs1_D = 0; Rs2_D = 0;
      PCSrcE = 0; dmem_req_M = 0; dmem_ready = 0;
      #12;
      chk("reset_outs", 32'(outs), 32'(NONE));
      chk("reset_timeout", 32'(mem_timeout), 0);
`ifdef HAZARD_PERF_CNT_EN
      chk("reset_lu_cnt", load_use_cnt, 0);
      chk("reset_mw_cnt", mem_wait_cnt, 0);
      chk("reset_fl_cnt", flush_cnt, 0);
`endif
      @(negedge clk); rst = 1'b1;

      // Load-use on Rs2, one bubble, then the load has moved on.
      drive(1, 5, 3, 5, 0, 0, 0); chk("lu_rs2", 32'(outs), 32'(LU));
      drive(0, 0, 3, 5, 0, 0, 0); chk("lu_after", 32'(outs), 32'(NONE));
      // Load to x0 never stalls.
      drive(1, 0, 0, 0, 0, 0, 0); chk("lu_x0", 32'(outs), 32'(NONE));
      // Load-use on Rs1.
      drive(1, 7, 7, 2, 0, 0, 0); chk("lu_rs1", 32'(outs), 32'(LU));
      // Non-load with matching register: forwarding handles it.
      drive(0, 7, 7, 2, 0, 0, 0); chk("nolu_alu", 32'(outs), 32'(NONE));
`ifdef HAZARD_PERF_CNT_EN
      chk("lu_cnt_2", load_use_cnt, 2);
`endif

      // Taken branch together with a load-use: branch wins, no stall.
      drive(1, 5, 5, 1, 1, 0, 0); chk("br_lu", 32'(outs), 32'(BR));
      drive(0, 0, 0, 0, 0, 0, 0); chk("br_after", 32'(outs), 32'(NONE));
`ifdef HAZARD_PERF_CNT_EN
      chk("lu_cnt_same", load_use_cnt, 2);
      chk("fl_cnt_1", flush_cnt, 1);
`endif

      // Memory wait: 3 stall cycles then ready.
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 1, 0); chk($sformatf("mwait_%0d", i), 32'(outs), 32'(MSTL));
      end
      drive(0, 0, 0, 0, 0, 1, 1); chk("mwait_ready", 32'(outs), 32'(NONE));
      drive(0, 0, 0, 0, 0, 0, 0); chk("mwait_idle", 32'(outs), 32'(NONE));
`ifdef HAZARD_PERF_CNT_EN
      chk("mw_cnt_3", mem_wait_cnt, 3);
`endif

      // Branch held in EX during a memory stall; flush only on ready cycle.
      drive(0, 0, 0, 0, 1, 1, 0); chk("br_mstall_0", 32'(outs), 32'(MSTL));
      drive(0, 0, 0, 0, 1, 1, 0); chk("br_mstall_1", 32'(outs), 32'(MSTL));
      drive(0, 0, 0, 0, 1, 1, 1); chk("br_mready", 32'(outs), 32'(BR));
      // Ready in the first cycle: no stall at all.
      drive(0, 0, 0, 0, 0, 1, 1); chk("mem_fast", 32'(outs), 32'(NONE));
      drive(0, 0, 0, 0, 0, 0, 0); chk("no_timeout_yet", 32'(mem_timeout), 0);

      // Timeout: 5 stall cycles with TIMEOUT_CYCLES=4, flag rises after the 5th.
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0, 1, 0);
         chk($sformatf("to_low_%0d", i), 32'(mem_timeout), 0);
      end
      drive(0, 0, 0, 0, 0, 1, 0); chk("to_set", 32'(mem_timeout), 1);
      drive(0, 0, 0, 0, 0, 1, 1); chk("to_ready", 32'(outs), 32'(NONE));
      drive(0, 0, 0, 0, 0, 0, 0); chk("to_sticky", 32'(mem_timeout), 1);

      // Asynchronous reset mid-wait clears the flag without a clock edge.
      drive(0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      #2 rst = 1'b0; dmem_req_M = 0;
      #1 chk("async_rst_to", 32'(mem_timeout), 0);
      @(negedge clk); rst = 1'b1;
      // Back in RUN with a cleared counter: a 3-cycle wait stays under limit.
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 1, 0); chk($sformatf("post_rst_%0d", i), 32'(outs), 32'(MSTL));
      end
      drive(0, 0, 0, 0, 0, 1, 1);
      drive(0, 0, 0, 0, 0, 0, 0); chk("post_rst_to", 32'(mem_timeout), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline stall/flush controller for the five-stage RISC-V core. It covers the hazards that operand forwarding cannot resolve: load-use dependencies, taken branches/jumps resolved in EX, and variable-latency data-memory accesses in MEM. It drives the enable/clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also tracks memory-wait duration for a sticky timeout flag.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: MEM_WAIT cycles after which mem_timeout sets (range 1..65535).
- CNT_W, default 32: width of the performance counters (used only with the perf feature).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemReadE  in  1  the instruction in EX is a load.
- RD_E  in  5  destination register in EX.
- Rs1_D, Rs2_D  in  5 each  source registers in ID.
- PCSrcE  in  1  taken branch/jump resolved in EX.
- dmem_req_M  in  1  load/store access active in MEM.
- dmem_ready  in  1  data memory completes the MEM access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE  out  1 each  clear IF/ID and ID/EX to a bubble (NOP, RegWrite=0, MemWrite=0).
- FlushW  out  1  insert a bubble into MEM/WB.
- mem_timeout  out  1  sticky; cleared only by reset.
- load_use_cnt, mem_wait_cnt, flush_cnt  out  CNT_W each  present only with HAZARD_PERF_CNT_EN.

## Operation
- memstall = dmem_req_M && !dmem_ready, evaluated in RUN and MEM_WAIT.
- lu = MemReadE && RD_E!=0 && (RD_E==Rs1_D || RD_E==Rs2_D).
- The FSM has two states.
  - RUN: if memstall, go to MEM_WAIT; otherwise stay in RUN.
  - MEM_WAIT: if dmem_ready, go to RUN; otherwise stay in MEM_WAIT.
- All outputs are combinational from the state and the inputs. Priority is memstall > PCSrcE > lu.
- When memstall: StallF=StallD=StallE=StallM=1 and FlushW=1. All other flushes are 0, so a branch frozen in EX is not lost.
- Otherwise, when PCSrcE: FlushD=FlushE=1. No stalls, and lu is ignored because the dependent instruction is squashed.
- Otherwise, when lu: StallF=StallD=1 and FlushE=1 for one cycle. On the next cycle the load is in MEM and lu is false.
- In every other case, all outputs are 0.
- Wait counter: 16 bits.
  - Cleared on entry to MEM_WAIT.
  - Increments each cycle the FSM is in MEM_WAIT.
  - Saturates at 0xFFFF.
  - mem_timeout sets when the counter reaches TIMEOUT_CYCLES.
- Reset mid-wait: the FSM returns to RUN, the counter clears, and mem_timeout clears. There is no replay; the core resets too.

## Timing
- Reset values:
  - State is RUN and the wait counter is 0.
  - mem_timeout and all perf counters are 0.
  - All stall/flush outputs are 0 while reset is held, because dmem_req_M is gated by reset upstream.
- Stall and flush take effect in the same cycle as the causing condition (zero latency).
- Load-use costs exactly one bubble.
- A memory access that gets dmem_ready after N cycles stalls for N cycles.
- The cycle in which dmem_ready=1: no stall, and the pipeline advances.
- A memory access with dmem_ready=1 in its first cycle never enters MEM_WAIT.
- Back-to-back memory accesses: RUN is re-entered for at least one cycle between them. Entering MEM_WAIT again clears the counter.
- mem_timeout sets on the clock edge where the counter equals TIMEOUT_CYCLES, that is, TIMEOUT_CYCLES+1 cycles after the stall began.

## Configuration
- HAZARD_PERF_CNT_EN defined: three saturating CNT_W-bit counters are built.
  - load_use_cnt increments once per lu bubble that is actually issued (lu && !PCSrcE && !memstall).
  - mem_wait_cnt increments each memstall cycle.
  - flush_cnt increments each cycle with FlushE caused by PCSrcE.
  - All three reset to 0.
- HAZARD_PERF_CNT_EN undefined: the counter ports and logic are absent, and stall/flush behaviour is identical.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (RUN, MEM_WAIT);
  - the wait-counter width constant (16);
  - the bubble control-word constant used by the pipeline registers on flush.
- Sub-module hazard_perf_counters contains the three saturating counters. It is instantiated only under HAZARD_PERF_CNT_EN.

## Test plan
- Load-use: lw x5 in EX with MemReadE=1, RD_E=5 and Rs2_D=5 -> StallF=StallD=FlushE=1 for exactly one cycle, then all 0. With RD_E=0 -> no stall.
- Taken branch plus load-use in the same cycle: PCSrcE=1, lu true -> FlushD=FlushE=1, StallF=0, and load_use_cnt is unchanged.
- Memory wait: dmem_req_M=1 with dmem_ready low for 3 cycles, then high -> all four stalls and FlushW are 1 for 3 cycles, 0 on the ready cycle, and mem_wait_cnt=3.
- Branch during a memory stall: PCSrcE=1 for 2 wait cycles and the ready cycle -> no flush in the 2 wait cycles, FlushD=FlushE=1 on the ready cycle.
- Timeout: TIMEOUT_CYCLES=4 and dmem_ready never asserts -> mem_timeout rises after 5 stall cycles and stays 1 after ready. An asynchronous rst low clears it and returns the FSM to RUN.
